// File: rtl/a2d_spi_responder_if.sv
// SPI pins and converter sample handshake of the A2D SPI responder.
// The slave modport is the responder's view; master is the initiator/converter side.
interface a2d_spi_responder_if;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        smpl_req;
  logic [2:0]  smpl_chnl;
  logic        smpl_vld;
  logic [11:0] smpl_data;
  logic        frm_err;
  logic        busy;

  modport slave (
    input  SS_n, SCLK, MOSI, smpl_vld, smpl_data,
    output MISO, smpl_req, smpl_chnl, frm_err, busy
  );

  modport master (
    output SS_n, SCLK, MOSI, smpl_vld, smpl_data,
    input  MISO, smpl_req, smpl_chnl, frm_err, busy
  );
endinterface

// File: rtl/a2d_spi_responder.sv
// SPI responder for an A2D converter: 16-bit frames, one-frame response pipeline.
// Optional macro A2D_RESP_INV_EN models an inverted-output converter.
module a2d_spi_responder (
  input  logic                    clk,
  input  logic                    rst,
  a2d_spi_responder_if.slave      bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

`ifdef A2D_RESP_INV_EN
  localparam logic [11:0] OVERRUN_VAL = 12'h000;
  logic [11:0] sample_val;
  assign sample_val = ~bus.smpl_data;
`else
  localparam logic [11:0] OVERRUN_VAL = 12'hFFF;
  logic [11:0] sample_val;
  assign sample_val = bus.smpl_data;
`endif

  state_t      state, state_nxt;
  logic        ss_s1, ss_s2, ss_s3;
  logic        sclk_s1, sclk_s2, sclk_s3;
  logic        mosi_s1, mosi_s2;
  logic        rst_q, ss_armed;
  logic [4:0]  bit_cnt;
  logic [15:0] tx_shift;
  logic [2:0]  chnl_shift;
  logic [11:0] resp_reg;
  logic [2:0]  chnl_q;
  logic        req_q, err_q;

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic        load_tx, load_resp, req_set, err_set;
  logic [15:0] tx_val;
  logic [11:0] resp_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1    <= 1'b1;
      ss_s2    <= 1'b1;
      ss_s3    <= 1'b1;
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      rst_q    <= 1'b1;
      ss_armed <= 1'b0;
    end else begin
      ss_s1    <= bus.SS_n;
      ss_s2    <= ss_s1;
      ss_s3    <= ss_s2;
      sclk_s1  <= bus.SCLK;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      mosi_s1  <= bus.MOSI;
      mosi_s2  <= mosi_s1;
      rst_q    <= 1'b0;
      // Arm only once a genuinely sampled SS_n high has been seen, so a select
      // still held low across reset release is not mistaken for a new frame.
      if (!rst_q && ss_s1) ss_armed <= 1'b1;
    end
  end

  assign ss_fall   = ss_armed & ss_s3 & ~ss_s2;
  assign ss_rise   = ~ss_s3 & ss_s2;
  assign sclk_rise = ~sclk_s3 & sclk_s2;
  assign sclk_fall = sclk_s3 & ~sclk_s2;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Sample handshake: smpl_req is a one-cycle request carrying smpl_chnl; the
  // converter answers later with a one-cycle smpl_vld and smpl_data. There is
  // no backpressure; a smpl_vld arriving while not in WAIT is dropped.
  always_comb begin
    state_nxt = state;
    load_tx   = 1'b0;
    tx_val    = 16'h0000;
    load_resp = 1'b0;
    resp_val  = resp_reg;
    req_set   = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          load_tx   = 1'b1;
          tx_val    = {4'h0, resp_reg};
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          if (bit_cnt == 5'd16) begin
            req_set   = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            err_set   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (ss_fall) begin
          load_tx   = 1'b1;
          tx_val    = {4'h0, OVERRUN_VAL};
          load_resp = 1'b1;
          resp_val  = OVERRUN_VAL;
          state_nxt = ST_SHIFT;
        end else if (bus.smpl_vld) begin
          load_resp = 1'b1;
          resp_val  = sample_val;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 5'd0;
      tx_shift   <= 16'h0000;
      chnl_shift <= 3'h0;
      resp_reg   <= 12'h000;
      chnl_q     <= 3'h0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      req_q <= req_set;
      err_q <= err_set;
      if (load_resp) resp_reg <= resp_val;
      if (req_set)   chnl_q   <= chnl_shift;
      if (load_tx) begin
        tx_shift <= tx_val;
        bit_cnt  <= 5'd0;
      end else if (state == ST_SHIFT) begin
        if (sclk_rise) begin
          // Received bits 2..4 (MSB first) are command bits [13:11].
          if (bit_cnt >= 5'd2 && bit_cnt <= 5'd4)
            chnl_shift <= {chnl_shift[1:0], mosi_s2};
          if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
        end
        if (sclk_fall) tx_shift <= {tx_shift[14:0], 1'b0};
      end
    end
  end

  assign bus.MISO      = ~rst & (state == ST_SHIFT) & tx_shift[15];
  assign bus.busy      = ~rst & (state != ST_IDLE);
  assign bus.smpl_req  = ~rst & req_q;
  assign bus.frm_err   = ~rst & err_q;
  assign bus.smpl_chnl = rst ? 3'h0 : chnl_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_a2d_spi_responder.sv
// Directed bench for a2d_spi_responder: vector table plus multi-cycle corner sequences.
module tb_a2d_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  a2d_spi_responder_if bus();

  a2d_spi_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

`ifdef A2D_RESP_INV_EN
  localparam logic [15:0] OVR_WORD = 16'h0000;
  localparam logic [15:0] A5C_WORD = 16'h05A3;
`else
  localparam logic [15:0] OVR_WORD = 16'h0FFF;
  localparam logic [15:0] A5C_WORD = 16'h0A5C;
`endif

  function automatic logic [15:0] word_of(input logic [11:0] d);
`ifdef A2D_RESP_INV_EN
    return {4'h0, ~d};
`else
    return {4'h0, d};
`endif
  endfunction

  typedef struct {
    logic [15:0] cmd;
    logic [2:0]  exp_chnl;
    logic [11:0] data;
    logic [15:0] exp_word;
  } vec_t;

  vec_t        vecs[4];
  int          tests = 0;
  int          fails = 0;
  int          req_cnt = 0;
  int          err_cnt = 0;
  logic [2:0]  req_chnl = 3'h0;
  logic [15:0] rx;
  logic [11:0] prev, d;
  int          r0, e0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.smpl_req) begin
        req_cnt++;
        req_chnl = bus.smpl_chnl;
      end
      if (bus.frm_err) err_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ss_low(input int half);
    bus.SS_n = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [15:0] cmd, input int n, input int half,
                            output logic [15:0] got);
    got = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (i < 16) bus.MOSI = cmd[15-i];
      else        bus.MOSI = 1'b0;
      repeat (half) @(negedge clk);
      got = {got[14:0], bus.MISO};
      bus.SCLK = 1'b1;
      repeat (half) @(negedge clk);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic ss_high(input int half);
    repeat (half) @(negedge clk);
    bus.SS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int n, input int half,
                           output logic [15:0] got);
    ss_low(half);
    clock_bits(cmd, n, half, got);
    ss_high(half);
  endtask

  task automatic give_sample(input logic [11:0] val);
    bus.smpl_data = val;
    bus.smpl_vld  = 1'b1;
    @(negedge clk);
    bus.smpl_vld  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{cmd: 16'hEFFF, exp_chnl: 3'h5, data: 12'hA5C, exp_word: 16'h0000};
    vecs[1] = '{cmd: 16'h1000, exp_chnl: 3'h2, data: 12'h123, exp_word: A5C_WORD};
    vecs[2] = '{cmd: 16'hBAAA, exp_chnl: 3'h7, data: 12'hFFF, exp_word: word_of(12'h123)};
    vecs[3] = '{cmd: 16'hC7FF, exp_chnl: 3'h0, data: 12'h3C7, exp_word: word_of(12'hFFF)};

    // Clock/reset
    rst = 1'b1;
    bus.SS_n = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    bus.smpl_vld = 1'b0; bus.smpl_data = 12'h000;
    repeat (4) @(negedge clk);
    check("rst_miso", bus.MISO, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_req", bus.smpl_req, 1'b0);
    check("rst_err", bus.frm_err, 1'b0);
    check("rst_chnl", bus.smpl_chnl, 3'h0);
    check("rst_state", state_dbg, 2'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Vector table: each frame returns the previous frame's sample
    for (int i = 0; i < 4; i++) begin
      r0 = req_cnt; e0 = err_cnt;
      spi_frame(vecs[i].cmd, 16, 5, rx);
      check("vec_word", rx, vecs[i].exp_word);
      check("vec_req_cnt", req_cnt - r0, 1);
      check("vec_chnl", req_chnl, vecs[i].exp_chnl);
      check("vec_no_err", err_cnt - e0, 0);
      check("vec_busy_wait", bus.busy, 1'b1);
      check("vec_miso_wait", bus.MISO, 1'b0);
      give_sample(vecs[i].data);
      check("vec_busy_idle", bus.busy, 1'b0);
    end

    // Short frame of 10 pulses, then an over-long frame of 20 pulses
    r0 = req_cnt; e0 = err_cnt;
    ss_low(5);
    clock_bits(16'hFFFF, 10, 5, rx);
    ss_high(5);
    check("short_err", err_cnt - e0, 1);
    check("short_no_req", req_cnt - r0, 0);
    check("short_busy", bus.busy, 1'b0);
    r0 = req_cnt; e0 = err_cnt;
    spi_frame(16'hFFFF, 20, 5, rx);
    check("long_err", err_cnt - e0, 1);
    check("long_no_req", req_cnt - r0, 0);
    r0 = req_cnt;
    spi_frame(16'h0800, 16, 5, rx);
    check("after_short_word", rx, word_of(12'h3C7));
    check("after_short_req", req_cnt - r0, 1);
    check("after_short_chnl", req_chnl, 3'h1);
    give_sample(12'h456);

    // Overrun: new frame starts while a sample is pending; a late vld is dropped
    spi_frame(16'h5800, 16, 5, rx);
    check("ovr_prev_word", rx, word_of(12'h456));
    check("ovr_chnl3", req_chnl, 3'h3);
    r0 = req_cnt;
    fork
      spi_frame(16'h3000, 16, 5, rx);
      begin
        repeat (30) @(negedge clk);
        give_sample(12'hBAD);
      end
    join
    check("ovr_word", rx, OVR_WORD);
    check("ovr_req", req_cnt - r0, 1);
    check("ovr_chnl6", req_chnl, 3'h6);
    check("ovr_busy", bus.busy, 1'b1);
    give_sample(12'h7E1);
    spi_frame(16'h0000, 16, 5, rx);
    check("ovr_late_ignored", rx, word_of(12'h7E1));
    give_sample(12'h9B2);

    // Reset after 8 bits, select held low across release
    e0 = err_cnt;
    ss_low(5);
    clock_bits(16'hFFFF, 8, 5, rx);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_miso", bus.MISO, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_err", bus.frm_err, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_restart", bus.busy, 1'b0);
    check("midrst_err_cnt", err_cnt - e0, 0);
    bus.SS_n = 1'b1;
    repeat (8) @(negedge clk);
    r0 = req_cnt;
    spi_frame(16'h2000, 16, 5, rx);
    check("midrst_word", rx, 16'h0000);
    check("midrst_req", req_cnt - r0, 1);
    check("midrst_chnl", req_chnl, 3'h4);
    give_sample(12'h5D5);
    prev = 12'h5D5;

    // All channels back-to-back, SCLK half-period of 4 clk
    for (int ch = 0; ch < 8; ch++) begin
      logic [2:0] c;
      c = 3'(ch);
      spi_frame({2'b10, c, 11'h2AA}, 16, 4, rx);
      check("sweep_word", rx, word_of(prev));
      check("sweep_chnl", req_chnl, c);
      d = {c, ~c, c, 3'b101};
      give_sample(d);
      prev = d;
    end
    spi_frame(16'h0000, 16, 4, rx);
    check("sweep_last_word", rx, word_of(prev));
    give_sample(12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/a2d_spi_responder.md
A2D_SPI_RESPONDER -- requirements
Module: a2d_spi_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port SS_n, input, 1 bit: SPI slave select, active-low, asynchronous to clk.
REQ-004 SHALL have port SCLK, input, 1 bit: SPI serial clock, idle low, asynchronous to clk.
REQ-005 SHALL have port MOSI, input, 1 bit: command data from the initiator, MSB first.
REQ-006 SHALL have port MISO, output, 1 bit: response data to the initiator, MSB first.
REQ-007 SHALL have port smpl_req, output, 1 bit: one-cycle request for a channel sample.
REQ-008 SHALL have port smpl_chnl, output, 3 bits: channel for smpl_req, held until the next request.
REQ-009 SHALL have port smpl_vld, input, 1 bit: smpl_data valid, single-cycle strobe.
REQ-010 SHALL have port smpl_data, input, 12 bits: sample value for smpl_chnl.
REQ-011 SHALL have port frm_err, output, 1 bit: one-cycle pulse on an aborted or short frame.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is active or a sample is pending.

Function
REQ-013 SHALL pass SS_n, SCLK and MOSI each through a 2-flop synchronizer; the SS_n synchronizer output and the SCLK synchronizer output SHALL each feed one extra flop for edge detection.
REQ-014 SHALL operate correctly only when SCLK high and low phases are each at least 4 clk periods; SS_n setup to the first SCLK rise SHALL be at least 4 clk periods.
REQ-015 SHALL use a 16-bit frame: MOSI is sampled on the synchronized SCLK rise, and MISO is updated on the synchronized SCLK fall.
REQ-016 SHALL use the following states: IDLE (SS_n high), SHIFT (frame active, 5-bit bit counter 0..16), WAIT (sample requested, smpl_vld not yet seen).
REQ-017 SHALL, on an SS_n fall in IDLE or WAIT, load the 16-bit TX shifter with {4'h0, resp_reg}, present its MSB on MISO in the same cycle, clear the bit counter, and enter SHIFT.
REQ-018 SHALL map the command as follows: command frame bits [13:11] are the channel; all other command bits are ignored.
REQ-019 SHALL, on an SS_n rise in SHIFT with the bit counter at 16, latch smpl_chnl, pulse smpl_req for one cycle, and enter WAIT.
REQ-020 SHALL, on an SS_n rise in SHIFT with the bit counter not at 16, pulse frm_err, issue no smpl_req, leave resp_reg unchanged, and enter IDLE.
REQ-021 SHALL treat SCLK edges beyond the 16th within a frame as a short frame: the counter saturates at 17 and frm_err pulses at the SS_n rise.
REQ-022 SHALL, in WAIT when smpl_vld is high, load resp_reg with smpl_data (subject to REQ-030) and enter IDLE; smpl_vld outside WAIT SHALL be ignored.
REQ-023 SHALL, on an SS_n fall in WAIT, set resp_reg to 12'hFFF, shift that value out, and drop the pending request; a later smpl_vld SHALL be ignored.
REQ-024 SHALL return, in each frame, the response to the previous completed frame's command (one-frame pipeline).
REQ-025 SHALL drive MISO to 0 whenever the state is IDLE or WAIT.
REQ-026 SHALL drive busy high in SHIFT and WAIT, and low in IDLE.

Reset
REQ-027 SHALL, while rst is high on a clk edge, force state to IDLE, resp_reg to 12'h000, and all synchronizer flops to idle levels (SS_n 1, SCLK 0, MOSI 0).
REQ-028 SHALL force outputs MISO=0, smpl_req=0, smpl_chnl=3'h0, frm_err=0 and busy=0 during reset.
REQ-029 SHALL abandon any frame in progress when reset is asserted, with no frm_err; after release, activity SHALL restart only on a fresh SS_n fall.

Configuration
REQ-030 SHALL implement macro A2D_RESP_INV_EN: when defined, resp_reg loads ~smpl_data (inverted-output converter model), and the WAIT-overrun value 12'hFFF of REQ-023 SHALL become 12'h000; when undefined, resp_reg loads smpl_data unmodified and the overrun value is 12'hFFF.

Verification
REQ-031 SHALL cover: first frame after reset, command channel 5 -> MISO word 16'h0000, smpl_req pulse, smpl_chnl=3'h5.
REQ-032 SHALL cover: smpl_data=12'hA5C supplied, then a second frame -> MISO word 16'h0A5C (16'h05A3 with A2D_RESP_INV_EN).
REQ-033 SHALL cover: a frame of 10 SCLK pulses then SS_n rise -> frm_err pulse, no smpl_req, next frame returns the previous resp_reg.
REQ-034 SHALL cover: SS_n falls in WAIT before smpl_vld -> MISO word 16'h0FFF (16'h0000 with A2D_RESP_INV_EN), and a late smpl_vld is ignored.
REQ-035 SHALL cover: rst asserted after 8 bits of a frame -> MISO=0, busy=0, no frm_err; the next full frame returns 16'h0000.
REQ-036 SHALL cover: all 8 channels back-to-back with SCLK half-period equal to 4 clk -> each frame returns the prior channel's data exactly.
